wb_commit_queue: RTL
====================

WB_COMMIT_QUEUE -- requirements
Module: wb_commit_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the queue entries; it SHALL be a power of two and at least 4.
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports in_valid_0 and in_valid_1, input, 1 bit each: result-valid flags; port 0 is older than port 1 in the same cycle.
REQ-006 The block SHALL have ports in_addr_0 and in_addr_1, input, 3 bits each: destination registers.
REQ-007 The block SHALL have ports in_data_0 and in_data_1, input, WIDTH each: result data.
REQ-008 The block SHALL have port in_ready, output, 1 bit: high when at least 2 slots are free.
REQ-009 The block SHALL have port drain_en, input, 1 bit: permits popping toward the register file.
REQ-010 The block SHALL have port flush, input, 1 bit: synchronous discard of all queued entries.
REQ-011 The block SHALL have ports wa_0 and wa_1, output, 3 bits each: register-file write addresses; 0 means no write.
REQ-012 The block SHALL have ports wd_0 and wd_1, output, WIDTH each: register-file write data.
REQ-013 The block SHALL have port count, output, log2(DEPTH)+1 bits: occupancy.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky error flag.

Function
REQ-015 An enqueue SHALL occur on a rising edge for each in_valid_x=1 with in_ready=1 and in_addr_x!=0.
REQ-016 An entry with in_addr_x=0 SHALL be discarded and SHALL NOT occupy a slot.
REQ-017 When both ports enqueue in one cycle, the port 0 entry SHALL be placed older than the port 1 entry; when only port 1 enqueues, it SHALL take the next slot with no hole left.
REQ-018 An in_valid_x=1 with in_addr_x!=0 while in_ready=0 SHALL drop the entry and set overflow=1 until reset.
REQ-019 in_ready SHALL equal (count <= DEPTH-2) and SHALL be derived combinationally from registered count only.
REQ-020 On each edge with drain_en=1, the block SHALL pop min(count,2) oldest entries and register them onto the write ports for the following cycle: the oldest on wa_0/wd_0, the next on wa_1/wd_1.
REQ-021 When one entry is popped, wa_1 SHALL be 0.
REQ-022 When nothing is popped (drain_en=0 or empty), wa_0 and wa_1 SHALL both be 0 in the following cycle, and wd_* SHALL hold their previous values.
REQ-023 Coalescing: if both popped entries have equal addresses, the block SHALL drive wa_0=0 and drive the younger entry on wa_1/wd_1, and both entries SHALL be removed.
REQ-024 Minimum latency SHALL be: enqueue at edge E, pop at edge E+1, visible on wa_* during the cycle after E+1.
REQ-025 Pops SHALL use entries present before the edge; same-edge enqueue and pop SHALL update count by the net amount.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; count SHALL reach DEPTH exactly at full.
REQ-027 flush=1 SHALL take priority at the edge: count and pointers go to 0, wa_0=wa_1=0 next cycle, enqueue and pop are ignored, and overflow is unchanged.
REQ-028 The block SHALL never drive wa_0 and wa_1 with the same nonzero address in one cycle.

Reset
REQ-029 Asserting reset (low) SHALL immediately force count=0, pointers=0, wa_0=wa_1=0, wd_0=wd_1=0 and overflow=0, giving in_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all entries, with no partial writes presented after assertion.
REQ-031 Storage array contents SHALL NOT need a reset.

Structure
REQ-032 A shared package SHALL hold the register-address width (3), the default data width (16), the ZERO data constant, and the no-write address constant 0.
REQ-033 The storage SHALL be one sub-module, wb_queue_mem, with DEPTH x (3+WIDTH) entries, two write ports and two combinational read ports; pointer, count and collision logic SHALL stay in wb_commit_queue.

Verification
REQ-034 Bench: after reset, enqueue (r3,0x1111) on port 0 and (r5,0x2222) on port 1 with drain_en=1 -> two cycles after the enqueue edge, wa_0=3/wd_0=0x1111 and wa_1=5/wd_1=0x2222.
REQ-035 Bench: enqueue (r2,0xAAAA) then (r2,0xBBBB) in one cycle -> one cycle shows wa_0=0, wa_1=2, wd_1=0xBBBB, after which count=0.
REQ-036 Bench: drain_en=0 with 7 single-entry enqueues (DEPTH=8) -> in_ready=0 at count=7; a further enqueue sets overflow=1 and count stays 7.
REQ-037 Bench: 20 sequential entries with alternating drain_en across pointer wrap -> register writes arrive in enqueue order with none lost.
REQ-038 Bench: flush with count=5 plus a simultaneous enqueue -> next cycle count=0 and wa_0=wa_1=0.
REQ-039 Bench: reset asserted low mid-stream with count=4 -> outputs zero immediately and in_ready=1 after release.

Source files
------------

// File: rtl/wb_commit_queue_pkg.sv
// Shared constants for the write-back commit queue: register address width,
// default data width and the "no write" address encoding.
package wb_commit_queue_pkg;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] ZERO_DATA = '0;
  localparam logic [ADDR_W-1:0] NO_WRITE = '0;
endpackage

// File: rtl/wb_queue_mem.sv
// Entry storage for the commit queue: two write ports, two combinational read ports.
// Contents are intentionally left unreset; only pointer/count state matters.
module wb_queue_mem
  import wb_commit_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int ENTRY_W = ADDR_W + WIDTH
) (
  input  logic               clk,
  input  logic               we_0,
  input  logic [PTR_W-1:0]   waddr_0,
  input  logic [ENTRY_W-1:0] wdata_0,
  input  logic               we_1,
  input  logic [PTR_W-1:0]   waddr_1,
  input  logic [ENTRY_W-1:0] wdata_1,
  input  logic [PTR_W-1:0]   raddr_0,
  output logic [ENTRY_W-1:0] rdata_0,
  input  logic [PTR_W-1:0]   raddr_1,
  output logic [ENTRY_W-1:0] rdata_1
);
  logic [ENTRY_W-1:0] mem [DEPTH];

  // The two write addresses are always distinct slots when both enables are set.
  always_ff @(posedge clk) begin
    if (we_0) mem[waddr_0] <= wdata_0;
    if (we_1) mem[waddr_1] <= wdata_1;
  end

  assign rdata_0 = mem[raddr_0];
  assign rdata_1 = mem[raddr_1];
endmodule

// File: rtl/wb_commit_queue.sv
// Two-wide in-order write-back queue: accepts up to two results per cycle and
// drains up to two per cycle onto registered register-file write ports.
module wb_commit_queue
  import wb_commit_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_0,
  input  logic [ADDR_W-1:0] in_addr_0,
  input  logic [WIDTH-1:0]  in_data_0,
  input  logic              in_valid_1,
  input  logic [ADDR_W-1:0] in_addr_1,
  input  logic [WIDTH-1:0]  in_data_1,
  output logic              in_ready,
  input  logic              drain_en,
  input  logic              flush,
  output logic [ADDR_W-1:0] wa_0,
  output logic [ADDR_W-1:0] wa_1,
  output logic [WIDTH-1:0]  wd_0,
  output logic [WIDTH-1:0]  wd_1,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);
  localparam int ENTRY_W = ADDR_W + WIDTH;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               acc_0, acc_1, en_0, en_1;
  logic [CNT_W-1:0]   n_enq, n_pop;
  logic [ENTRY_W-1:0] entry_0, entry_1, head_0, head_1;
  logic [ADDR_W-1:0]  head_addr_0, head_addr_1;
  logic [WIDTH-1:0]   head_data_0, head_data_1;

  // Handshake: a port's result is taken at a rising edge when in_valid_x=1,
  // in_addr_x!=0 and in_ready=1; in_ready depends only on registered count,
  // so it never combinationally depends on in_valid_x.
  assign in_ready = (count <= READY_MAX);

  assign acc_0 = in_valid_0 && (in_addr_0 != NO_WRITE);
  assign acc_1 = in_valid_1 && (in_addr_1 != NO_WRITE);
  assign en_0  = acc_0 && in_ready && !flush;
  assign en_1  = acc_1 && in_ready && !flush;
  assign n_enq = CNT_W'(en_0) + CNT_W'(en_1);

  always_comb begin
    n_pop = '0;
    if (drain_en && !flush) n_pop = (count >= CNT_TWO) ? CNT_TWO : count;
  end

  assign entry_0 = {in_addr_0, in_data_0};
  assign entry_1 = {in_addr_1, in_data_1};

  // A lone port-1 result takes the wr_ptr slot so no hole is left.
  wb_queue_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
    .clk     (clk),
    .we_0    (en_0 || en_1),
    .waddr_0 (wr_ptr),
    .wdata_0 (en_0 ? entry_0 : entry_1),
    .we_1    (en_0 && en_1),
    .waddr_1 (wr_ptr + PTR_W'(1)),
    .wdata_1 (entry_1),
    .raddr_0 (rd_ptr),
    .rdata_0 (head_0),
    .raddr_1 (rd_ptr + PTR_W'(1)),
    .rdata_1 (head_1)
  );

  assign {head_addr_0, head_data_0} = head_0;
  assign {head_addr_1, head_data_1} = head_1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      wa_0     <= NO_WRITE;
      wa_1     <= NO_WRITE;
      wd_0     <= '0;
      wd_1     <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wa_0   <= NO_WRITE;
      wa_1   <= NO_WRITE;
    end else begin
      wr_ptr <= wr_ptr + n_enq[PTR_W-1:0];
      rd_ptr <= rd_ptr + n_pop[PTR_W-1:0];
      count  <= count + n_enq - n_pop;
      if ((acc_0 || acc_1) && !in_ready) overflow <= 1'b1;
      wa_0 <= NO_WRITE;
      wa_1 <= NO_WRITE;
      if (n_pop == CNT_TWO) begin
        // Two writes to one register collapse into the younger value.
        if (head_addr_0 != head_addr_1) begin
          wa_0 <= head_addr_0;
          wd_0 <= head_data_0;
        end
        wa_1 <= head_addr_1;
        wd_1 <= head_data_1;
      end else if (n_pop != '0) begin
        wa_0 <= head_addr_0;
        wd_0 <= head_data_0;
      end
    end
  end
endmodule
